round_controller: RTL
=====================

# round_controller

Sequences one round of hangman between the PS/2 keyboard handler and the display/level logic. It accepts decoded key events, fetches the selected word's letter-presence mask from the word ROM, and tracks guessed letters and remaining lives. It detects win and loss and handles restart. It replaces the ad-hoc wrong-guess counter and the separate start/win/lose sequencing with one synchronous FSM, so every state change happens on `clk`.

## Interface
- `LIVES`, default 4: wrong guesses allowed per round; range 1..15.
- `RAM_LATENCY`, default 2: cycles from `ram_addr` change to valid `ram_q`. The word ROM has registered address and registered output.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  reset, asynchronous, active-high.
- `key_valid`  in  1  one-cycle pulse; `key_code` is valid this cycle.
- `key_code`  in  5  key code:
  - 0..25 are letters A..Z.
  - 26 is START.
  - 27..31 are ignored in all phases.
- `word_sel`  in  4  word index, sampled only when a START is accepted.
- `ram_addr`  out  4  word ROM address.
- `ram_q`  in  26  letter-presence mask of the addressed word; bit i means letter i occurs in the word.
- `guessed`  out  26  letters guessed this round.
- `hits`  out  26  `guessed & present`; drives the VGA reveal mask.
- `lives`  out  4  remaining wrong guesses.
- `phase`  out  3  current FSM phase: IDLE=0, FETCH=1, PLAY=2, WIN=3, LOSE=4.
- `wrong_pulse`  out  1  one-cycle pulse for a new letter that is not in the word.
- `dup_pulse`  out  1  one-cycle pulse for an already-guessed letter.

## Operation
- Reset values:
  - `phase`=IDLE, `ram_addr`=0.
  - `guessed`=0, internal `present`=0, `hits`=0.
  - `lives`=LIVES, both pulses 0.
- IDLE, WIN, LOSE: a START key (`key_valid` with `key_code`=26) begins a round:
  - `ram_addr` ← `word_sel`.
  - `guessed` ← 0, `lives` ← LIVES.
  - Fetch counter ← RAM_LATENCY; go to FETCH.
  - Letter keys are ignored in these phases.
- FETCH:
  - Counter decrements each cycle.
  - When the counter is 0: `present` ← `ram_q`.
  - If `ram_q`==0 (empty word), go to WIN; otherwise go to PLAY.
  - All keys, including START, are ignored during FETCH.
- PLAY, letter key L (0..25):
  - `guessed[L]` already set: assert `dup_pulse`; no other change.
  - Else if `present[L]` is set: set `guessed[L]`.
  - Else: set `guessed[L]`, decrement `lives`, assert `wrong_pulse`.
  - Win check: `present & ~guessed_next` == 0 → WIN.
  - Loss check: `lives_next` == 0 → LOSE.
  - Both checks use next-state values and transition on the same edge as the update.
  - Win and loss are mutually exclusive: a hit never decrements lives.
- PLAY, START key: ignored. There is no mid-round restart; only `reset` aborts a round.
- `lives` never decrements below 0. Decrement occurs only in PLAY, and PLAY exits on reaching 0.
- `hits` is combinational from registers: `guessed & present`.
- Reset asserted mid-round (any phase): all registers return to their reset values immediately, with no wait for `clk`.

## Timing
- Key accepted on the rising edge where `key_valid`=1. `guessed`, `lives`, `phase` and the pulses reflect it in the following cycle.
- Pulses last exactly one cycle.
- START accepted at edge 0:
  - `phase`=FETCH and `ram_addr` valid from cycle 1.
  - `present` captured at edge RAM_LATENCY+1.
  - `phase`=PLAY from cycle RAM_LATENCY+2; this is cycle 4 with default parameters.
- Back-to-back `key_valid` pulses in PLAY (every cycle) are each processed in order, with no drops.
- `word_sel` changes outside the START cycle have no effect.

## Structure
- Shared package `hangman_pkg` holds:
  - `phase_t` enum (IDLE, FETCH, PLAY, WIN, LOSE with the codes above).
  - `KEY_START`=26 and `NUM_LETTERS`=26.
  - `LETTER_W`=5.
- Single module and single FSM; no sub-module.
- The fetch counter is `$clog2(RAM_LATENCY+1)` bits wide. The top-level instantiates it between `keyboard_handler`, `word_ram` and `vga`.

## Test plan
- Reset, then START with `word_sel`=3 → `ram_addr`=3; `phase` goes 1 at cycle 1 and 2 at cycle 4; `lives`=4; `guessed`=0.
- Word mask `0x0000013` (letters A, B, E); keys A, B, E → `hits`=`0x13`; `phase`=WIN the cycle after E; `lives` remains 4.
- Same word; keys Z, Y, X, W → `wrong_pulse` four times; `lives` 3→2→1→0; `phase`=LOSE after W; `guessed`=`0x3C00000`.
- Key A twice in PLAY → second A gives `dup_pulse`=1 with `guessed` and `lives` unchanged; codes 27 and 26 in PLAY → no change.
- START during FETCH, and letters during WIN → ignored; START in LOSE with `word_sel`=5 → new round: `ram_addr`=5, `guessed`=0, `lives`=4.
- Assert `reset` between edges mid-PLAY → outputs return to reset values at once; `ram_q`=0 at fetch → `phase`=WIN directly from FETCH.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman round logic: key codes, letter
// count and the FSM phase encoding seen by the display/level logic.
package hangman_pkg;

  localparam int NUM_LETTERS = 26;
  localparam int LETTER_W    = 5;

  localparam logic [LETTER_W-1:0] KEY_START = 5'd26;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PLAY  = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } phase_t;

endpackage

// File: rtl/round_controller.sv
// One round of hangman: accepts decoded key events, fetches the chosen
// word's letter-presence mask from the word ROM, tracks guessed letters
// and remaining lives, and detects win/loss. A single synchronous FSM
// owns all sequencing; only reset acts outside the clock.
module round_controller
  import hangman_pkg::*;
#(
  parameter int LIVES       = 4,
  parameter int RAM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [LETTER_W-1:0]    key_code,
  input  logic [3:0]             word_sel,
  output logic [3:0]             ram_addr,
  input  logic [NUM_LETTERS-1:0] ram_q,
  output logic [NUM_LETTERS-1:0] guessed,
  output logic [NUM_LETTERS-1:0] hits,
  output logic [3:0]             lives,
  output logic [2:0]             phase,
  output logic                   wrong_pulse,
  output logic                   dup_pulse
);

  localparam int CNT_W = $clog2(RAM_LATENCY + 1);

  localparam logic [CNT_W-1:0]        CNT_INIT    = CNT_W'(RAM_LATENCY);
  localparam logic [3:0]              LIVES_INIT  = 4'(LIVES);
  localparam logic [LETTER_W-1:0]     LETTER_LAST = LETTER_W'(NUM_LETTERS - 1);
  localparam logic [NUM_LETTERS-1:0]  ONE_HOT0    = {{(NUM_LETTERS-1){1'b0}}, 1'b1};

  phase_t                 phase_q,   phase_d;
  logic [3:0]             addr_q,    addr_d;
  logic [NUM_LETTERS-1:0] guessed_q, guessed_d;
  logic [NUM_LETTERS-1:0] present_q, present_d;
  logic [3:0]             lives_q,   lives_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic                   wrong_q,   wrong_d;
  logic                   dup_q,     dup_d;

  logic                   isStart;
  logic                   isLetter;
  logic [NUM_LETTERS-1:0] letterMask;

  assign isStart    = key_valid && (key_code == KEY_START);
  assign isLetter   = key_valid && (key_code <= LETTER_LAST);
  assign letterMask = ONE_HOT0 << key_code;

  // Next-state logic: start a round, wait out the ROM latency, then score
  // each letter; win/loss are judged on the post-update values so the
  // phase changes on the same edge as the guess that decides it.
  always_comb begin
    phase_d   = phase_q;
    addr_d    = addr_q;
    guessed_d = guessed_q;
    present_d = present_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    wrong_d   = 1'b0;
    dup_d     = 1'b0;

    case (phase_q)
      IDLE, WIN, LOSE: begin
        if (isStart) begin
          addr_d    = word_sel;
          guessed_d = '0;
          lives_d   = LIVES_INIT;
          cnt_d     = CNT_INIT;
          phase_d   = FETCH;
        end
      end

      FETCH: begin
        if (cnt_q == '0) begin
          present_d = ram_q;
          phase_d   = (ram_q == '0) ? WIN : PLAY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      PLAY: begin
        if (isLetter) begin
          if ((guessed_q & letterMask) != '0) begin
            dup_d = 1'b1;
          end else begin
            guessed_d = guessed_q | letterMask;
            if ((present_q & letterMask) == '0) begin
              lives_d = lives_q - 4'd1;
              wrong_d = 1'b1;
            end
            if ((present_q & ~guessed_d) == '0) begin
              phase_d = WIN;
            end else if (lives_d == 4'd0) begin
              phase_d = LOSE;
            end
          end
        end
      end

      default: phase_d = IDLE;
    endcase
  end

  // State registers; reset aborts a round in any phase without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= IDLE;
      addr_q    <= '0;
      guessed_q <= '0;
      present_q <= '0;
      lives_q   <= LIVES_INIT;
      cnt_q     <= '0;
      wrong_q   <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      guessed_q <= guessed_d;
      present_q <= present_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
      wrong_q   <= wrong_d;
      dup_q     <= dup_d;
    end
  end

  assign phase       = phase_q;
  assign ram_addr    = addr_q;
  assign guessed     = guessed_q;
  assign hits        = guessed_q & present_q;
  assign lives       = lives_q;
  assign wrong_pulse = wrong_q;
  assign dup_pulse   = dup_q;

endmodule
